// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared state codes, round bounds and round type for the Ascon control FSM
package ascon_pack;

    // Round-constant index carried to the permutation datapath
    typedef logic [3:0] round_t;

    localparam round_t ROUND_FIRST = 4'd0;
    localparam round_t ROUND_MID   = 4'd6;
    localparam round_t ROUND_LAST  = 4'd11;

    // Controller state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_INIT    = 3'd1;
    localparam state_t ST_WAIT_AD = 3'd2;
    localparam state_t ST_AD      = 3'd3;
    localparam state_t ST_WAIT_PT = 3'd4;
    localparam state_t ST_PT      = 3'd5;
    localparam state_t ST_FINAL   = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    // True for states in which the permutation is clocked
    function automatic logic is_compute(input state_t s);
        return (s == ST_INIT) || (s == ST_AD) || (s == ST_PT) || (s == ST_FINAL);
    endfunction

endpackage

// File: rtl/round_counter.sv
// rtl/round_counter.sv - permutation round counter with load-0/load-6/increment and last-round flag
module round_counter
    import ascon_pack::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load_zero,
    input  logic   load_mid,
    input  logic   inc,
    output round_t round,
    output logic   last
);

    round_t count;

    // Loads take priority over increment; the controller never increments past the last round
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= ROUND_FIRST;
        end else if (load_zero) begin
            count <= ROUND_FIRST;
        end else if (load_mid) begin
            count <= ROUND_MID;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

    assign round = count;
    assign last  = (count == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// rtl/ascon_fsm.sv - Ascon encryption controller; ASCON_AD_EN enables the associated-data phase
module ascon_fsm
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       last_block_i,
    output logic [3:0] round_o,
    output logic       init_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_o,
    output logic       en_xor_lsb_o,
    output logic       en_reg_state_o,
    output logic       data_ack_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       end_o
);

    state_t state;
    state_t state_next;
    round_t round;
    logic   round_last;
    logic   round_first;
    logic   round_mid;
    logic   load_zero;
    logic   load_mid;
    logic   inc;
    logic   computing;

    round_counter u_round_counter (
        .clock     (clock_i),
        .reset     (reset_i),
        .load_zero (load_zero),
        .load_mid  (load_mid),
        .inc       (inc),
        .round     (round),
        .last      (round_last)
    );

    assign round_first = (round == ROUND_FIRST);
    assign round_mid   = (round == ROUND_MID);
    assign computing   = is_compute(state);

    // State register; reset wins over any pending start
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and round-counter control; counter returns to 0 whenever a permutation ends
    always_comb begin
        state_next = state;
        load_zero  = 1'b0;
        load_mid   = 1'b0;
        inc        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_INIT;
                    load_zero  = 1'b1;
                end
            end
            ST_INIT: begin
                if (round_last) begin
`ifdef ASCON_AD_EN
                    state_next = ST_WAIT_AD;
`else
                    state_next = ST_WAIT_PT;
`endif
                    load_zero  = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
`ifdef ASCON_AD_EN
            ST_WAIT_AD: begin
                if (data_valid_i) begin
                    state_next = ST_AD;
                    load_mid   = 1'b1;
                end
            end
            ST_AD: begin
                if (round_last) begin
                    state_next = ST_WAIT_PT;
                    load_zero  = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
`endif
            ST_WAIT_PT: begin
                if (data_valid_i) begin
                    if (last_block_i) begin
                        state_next = ST_FINAL;
                        load_zero  = 1'b1;
                    end else begin
                        state_next = ST_PT;
                        load_mid   = 1'b1;
                    end
                end
            end
            ST_PT: begin
                if (round_last) begin
                    state_next = ST_WAIT_PT;
                    load_zero  = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
            ST_FINAL: begin
                if (round_last) begin
                    state_next = ST_DONE;
                    load_zero  = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_next = ST_INIT;
                    load_zero  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                load_zero  = 1'b1;
            end
        endcase
    end

    // Datapath strobes decoded from state and round; acceptance strobes follow the host handshake
    always_comb begin
        round_o            = computing ? round : ROUND_FIRST;
        init_state_o       = (state == ST_INIT) && round_first;
        en_xor_key_begin_o = (state == ST_FINAL) && round_first;
        en_xor_key_o       = ((state == ST_INIT) || (state == ST_FINAL)) && round_last;
        tag_valid_o        = (state == ST_FINAL) && round_last;
        en_reg_state_o     = computing;
        end_o              = (state == ST_DONE);
`ifdef ASCON_AD_EN
        en_xor_data_o      = (((state == ST_AD) || (state == ST_PT)) && round_mid)
                           || ((state == ST_FINAL) && round_first);
        en_xor_lsb_o       = (state == ST_AD) && round_last;
        data_ack_o         = ((state == ST_WAIT_AD) || (state == ST_WAIT_PT)) && data_valid_i;
`else
        en_xor_data_o      = ((state == ST_PT) && round_mid)
                           || ((state == ST_FINAL) && round_first);
        en_xor_lsb_o       = (state == ST_INIT) && round_last;
        data_ack_o         = (state == ST_WAIT_PT) && data_valid_i;
`endif
        cipher_valid_o     = ((state == ST_PT) && round_mid)
                           || ((state == ST_WAIT_PT) && data_valid_i && last_block_i);
    end

endmodule
